// File: rtl/fc_pkg.sv
// Shared widths, segment-type encodings and FSM states for the FC layer read controller.
package fc_pkg;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [2:0] DT_IDLE   = 3'b000;
    localparam logic [2:0] DT_DATA   = 3'b001;
    localparam logic [2:0] DT_WEIGHT = 3'b010;
    localparam logic [2:0] DT_BIAS   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AWAIT,
        S_READ,
        S_DRAIN,
        S_NEXT,
        S_END
    } state_e;

    // Segment order is data -> weight -> bias; anything else falls back to idle.
    function automatic logic [2:0] next_type(input logic [2:0] t);
        case (t)
            DT_DATA:   next_type = DT_WEIGHT;
            DT_WEIGHT: next_type = DT_BIAS;
            default:   next_type = DT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/fc_rd_addr_gen.sv
// Per-segment base register plus issued/returned/outstanding word counters; drives the
// memory read request and word address for the active segment.
module fc_rd_addr_gen
    import fc_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic              issue_en_i,
    input  logic              gnt_i,
    input  logic              ret_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              issue_done_o,
    output logic              ret_done_o,
    output logic              ret_last_o
);

    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  issued_q, returned_q, outst_q;
    logic              take, dec;

    // Request depends only on registered state, so it and the address stay
    // stable while a request waits for its grant.
    assign req_o        = issue_en_i && (issued_q < len_i) && (outst_q < CNT_W'(MAX_OUTST));
    assign addr_o       = base_q + ADDR_W'(issued_q);
    assign take         = req_o && gnt_i;
    assign dec          = ret_i && (outst_q != '0);
    assign issue_done_o = (issued_q == len_i);
    assign ret_done_o   = (returned_q == len_i);
    assign ret_last_o   = ret_i && ((returned_q + 16'd1) == len_i);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            issued_q   <= '0;
            returned_q <= '0;
            outst_q    <= '0;
        end else if (ld_i) begin
            base_q     <= base_i;
            issued_q   <= '0;
            returned_q <= '0;
            outst_q    <= '0;
        end else begin
            if (take)
                issued_q <= issued_q + 16'd1;
            if (ret_i)
                returned_q <= returned_q + 16'd1;
            if (take && !dec)
                outst_q <= outst_q + 16'd1;
            else if (!take && dec)
                outst_q <= outst_q - 16'd1;
        end
    end

endmodule

// File: rtl/fc_rd_ctrl.sv
// FC layer read controller: fetches data, weight and bias segments in turn, asking the
// controller for each base address and streaming the returned words out tagged by type.
module fc_rd_ctrl
    import fc_pkg::*;
#(
    parameter int DATA_LEN   = 16,
    parameter int WEIGHT_LEN = 64,
    parameter int BIAS_LEN   = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fc_en,
    input  logic              NcNrc_initAddrEn,
    input  logic [ADDR_W-1:0] NcNrc_initAddr,
    output logic              NrcNc_initAddrRq,
    output logic [2:0]        NrcNc_dataType,
    output logic              NrcNc_rd_end,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_rvalid,
    input  logic [DATA_W-1:0] mem_rd_rdata,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [2:0]        rd_type,
    output logic              rd_last
);

    localparam logic [CNT_W-1:0] D_LEN = CNT_W'(DATA_LEN);
    localparam logic [CNT_W-1:0] W_LEN = CNT_W'(WEIGHT_LEN);
    localparam logic [CNT_W-1:0] B_LEN = CNT_W'(BIAS_LEN);

    state_e            state_q;
    logic [1:0]        wait_q;
    logic [2:0]        type_q;
    logic              rq_q, end_q;
    logic              rd_valid_q, rd_last_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [2:0]        rd_type_q;
    logic [CNT_W-1:0]  len;
    logic              ld, accept, issue_done, ret_done, ret_last;

    always_comb begin
        len = D_LEN;
        case (type_q)
            DT_WEIGHT: len = W_LEN;
            DT_BIAS:   len = B_LEN;
            default:   len = D_LEN;
        endcase
    end

    assign ld     = (state_q == S_AWAIT) && (wait_q == 2'd0) && NcNrc_initAddrEn;
    // Responses outside READ/DRAIN are strays (e.g. from reads aborted by reset).
    assign accept = mem_rd_rvalid && ((state_q == S_READ) || (state_q == S_DRAIN));

    fc_rd_addr_gen #(.MAX_OUTST(MAX_OUTST)) u_addr_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .ld_i         (ld),
        .base_i       (NcNrc_initAddr),
        .len_i        (len),
        .issue_en_i   (state_q == S_READ),
        .gnt_i        (mem_rd_gnt),
        .ret_i        (accept),
        .req_o        (mem_rd_req),
        .addr_o       (mem_rd_addr),
        .issue_done_o (issue_done),
        .ret_done_o   (ret_done),
        .ret_last_o   (ret_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= 2'd0;
            type_q  <= DT_IDLE;
            rq_q    <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            rq_q  <= 1'b0;
            end_q <= 1'b0;
            case (state_q)
                S_IDLE: if (fc_en) begin
                    state_q <= S_AWAIT;
                    type_q  <= DT_DATA;
                    wait_q  <= 2'd2;
                end
                S_AWAIT: begin
                    if (wait_q != 2'd0)
                        wait_q <= wait_q - 2'd1;
                    else if (NcNrc_initAddrEn)
                        state_q <= S_READ;
                end
                S_READ: if (issue_done) state_q <= S_DRAIN;
                S_DRAIN: if (ret_done) begin
                    if (type_q == DT_BIAS) begin
                        state_q <= S_END;
                        end_q   <= 1'b1;
                        type_q  <= DT_IDLE;
                    end else begin
                        state_q <= S_NEXT;
                        rq_q    <= 1'b1;
                    end
                end
                S_NEXT: begin
                    type_q  <= next_type(type_q);
                    wait_q  <= 2'd2;
                    state_q <= S_AWAIT;
                end
                S_END:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_type_q  <= DT_IDLE;
            rd_last_q  <= 1'b0;
        end else begin
            rd_valid_q <= accept;
            rd_last_q  <= ret_last;
            if (accept) begin
                rd_data_q <= mem_rd_rdata;
                rd_type_q <= type_q;
            end
        end
    end

    assign NrcNc_initAddrRq = rq_q;
    assign NrcNc_rd_end     = end_q;
    assign NrcNc_dataType   = type_q;
    assign rd_valid         = rd_valid_q;
    assign rd_data          = rd_data_q;
    assign rd_type          = rd_type_q;
    assign rd_last          = rd_last_q;

endmodule

// File: tb/tb_fc_rd_ctrl.sv
// Directed bench for fc_rd_ctrl: nominal layer, address wrap, late address, grant stall,
// and reset with reads in flight. Memory answers 3 cycles after grant with {4'hD, addr}.
module tb_fc_rd_ctrl;
    import fc_pkg::*;

    localparam int DL = 4, WL = 16, BL = 4, MO = 4;
    localparam int TOT = DL + WL + BL;

    logic              clk = 1'b0;
    logic              rst_n, fc_en, NcNrc_initAddrEn;
    logic [ADDR_W-1:0] NcNrc_initAddr;
    logic              NrcNc_initAddrRq, NrcNc_rd_end;
    logic [2:0]        NrcNc_dataType;
    logic              mem_rd_req, mem_rd_gnt, mem_rd_rvalid;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [DATA_W-1:0] mem_rd_rdata;
    logic              rd_valid, rd_last;
    logic [DATA_W-1:0] rd_data;
    logic [2:0]        rd_type;

    always #5 clk = ~clk;

    fc_rd_ctrl #(.DATA_LEN(DL), .WEIGHT_LEN(WL), .BIAS_LEN(BL), .MAX_OUTST(MO)) dut (
        .clk(clk), .rst_n(rst_n), .fc_en(fc_en),
        .NcNrc_initAddrEn(NcNrc_initAddrEn), .NcNrc_initAddr(NcNrc_initAddr),
        .NrcNc_initAddrRq(NrcNc_initAddrRq), .NrcNc_dataType(NrcNc_dataType),
        .NrcNc_rd_end(NrcNc_rd_end), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_gnt(mem_rd_gnt), .mem_rd_rvalid(mem_rd_rvalid), .mem_rd_rdata(mem_rd_rdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_type(rd_type), .rd_last(rd_last)
    );

    // Memory: fixed 3-cycle response pipe, deliberately not reset so aborted reads return.
    logic [2:0]             pv = '0;
    logic [2:0][ADDR_W-1:0] pa = '0;
    always @(posedge clk) begin
        pv <= {pv[1:0], mem_rd_req & mem_rd_gnt};
        pa <= {pa[1:0], mem_rd_addr};
    end
    assign mem_rd_rvalid = pv[2];
    assign mem_rd_rdata  = {4'hD, pa[2]};

    logic [35:0]       got_q[$];
    logic [ADDR_W-1:0] addr_q[$];
    int rq_cnt = 0, end_cnt = 0, both_cnt = 0, outst = 0, max_outst = 0;

    always @(posedge clk) begin
        if (mem_rd_req && mem_rd_gnt) addr_q.push_back(mem_rd_addr);
        if (!rst_n)
            outst <= 0;
        else
            outst <= outst + ((mem_rd_req && mem_rd_gnt) ? 1 : 0)
                           - ((mem_rd_rvalid && outst > 0) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (rd_valid) got_q.push_back({rd_last, rd_type, rd_data});
        if (NrcNc_initAddrRq) rq_cnt <= rq_cnt + 1;
        if (NrcNc_rd_end) end_cnt <= end_cnt + 1;
        if (NrcNc_initAddrRq && NrcNc_rd_end) both_cnt <= both_cnt + 1;
        if (outst > max_outst) max_outst <= outst;
    end

    int tests = 0, fails = 0;
    logic [35:0]       exp_w[$];
    logic [ADDR_W-1:0] exp_a[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_seg(input logic [ADDR_W-1:0] base, input int len, input logic [2:0] t);
        logic [ADDR_W-1:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + ADDR_W'(i);
            exp_a.push_back(a);
            exp_w.push_back({(i == len - 1), t, 4'hD, a});
        end
    endtask

    task automatic wait_sig(input bit want_end, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (want_end ? NrcNc_rd_end : NrcNc_initAddrRq) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {mem_rd_req, mem_rd_addr, NrcNc_initAddrRq, NrcNc_dataType, NrcNc_rd_end}, '0);
        chk({tag, "_out"}, {rd_valid, rd_data, rd_type, rd_last}, '0);
    endtask

    task automatic run_layer(input logic [ADDR_W-1:0] b0, b1, b2, input int late, input bit bp);
        int wi, ai, rq0, end0;
        bit ok, stable;
        logic hr;
        logic [ADDR_W-1:0] ha;
        wi = got_q.size(); ai = addr_q.size(); rq0 = rq_cnt; end0 = end_cnt;
        exp_w.delete(); exp_a.delete();
        exp_seg(b0, DL, DT_DATA); exp_seg(b1, WL, DT_WEIGHT); exp_seg(b2, BL, DT_BIAS);

        NcNrc_initAddr = b0; NcNrc_initAddrEn = 1'b1; fc_en = 1'b1;
        @(negedge clk);
        fc_en = 1'b0;
        chk("start_type", NrcNc_dataType, DT_DATA);
        chk("start_no_rq", NrcNc_initAddrRq, 0);

        wait_sig(1'b0, ok);
        chk("rq1_seen", ok, 1);
        chk("rq1_type", NrcNc_dataType, DT_DATA);
        NcNrc_initAddr = b1;
        if (late > 0) begin
            NcNrc_initAddrEn = 1'b0;
            stable = 1'b1;
            repeat (late) begin
                @(negedge clk);
                if (mem_rd_req !== 1'b0 || NrcNc_dataType !== DT_WEIGHT) stable = 1'b0;
            end
            chk("late_wait", stable, 1);
            NcNrc_initAddrEn = 1'b1;
            @(negedge clk);
            chk("late_req", mem_rd_req, 1);
            chk("late_addr", mem_rd_addr, b1);
        end
        if (bp) begin
            repeat (4) @(negedge clk);
            mem_rd_gnt = 1'b0;
            @(negedge clk);
            hr = mem_rd_req; ha = mem_rd_addr;
            stable = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (mem_rd_req !== hr || mem_rd_addr !== ha) stable = 1'b0;
            end
            chk("bp_req", hr, 1);
            chk("bp_hold", stable, 1);
            mem_rd_gnt = 1'b1;
        end

        wait_sig(1'b0, ok);
        chk("rq2_seen", ok, 1);
        chk("rq2_type", NrcNc_dataType, DT_WEIGHT);
        NcNrc_initAddr = b2;

        wait_sig(1'b1, ok);
        chk("end_seen", ok, 1);
        chk("end_type", NrcNc_dataType, DT_IDLE);
        chk("end_no_rq", NrcNc_initAddrRq, 0);
        @(negedge clk);
        chk("end_pulse", NrcNc_rd_end, 0);
        repeat (3) @(negedge clk);

        chk("word_cnt", got_q.size() - wi, TOT);
        chk("addr_cnt", addr_q.size() - ai, TOT);
        chk("rq_cnt", rq_cnt - rq0, 2);
        chk("end_cnt", end_cnt - end0, 1);
        if (got_q.size() - wi == TOT)
            for (int i = 0; i < TOT; i++) chk($sformatf("word%0d", i), got_q[wi + i], exp_w[i]);
        if (addr_q.size() - ai == TOT)
            for (int i = 0; i < TOT; i++) chk($sformatf("addr%0d", i), addr_q[ai + i], exp_a[i]);
    endtask

    initial begin
        int wi;
        rst_n = 1'b0; fc_en = 1'b0; NcNrc_initAddrEn = 1'b0; NcNrc_initAddr = '0; mem_rd_gnt = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_layer(28'h100, 28'h2000, 28'h40, 0, 1'b0);
        run_layer(28'hFFFFFFE, 28'h3000, 28'h50, 5, 1'b1);

        // Reset with three reads in flight; their responses must vanish.
        NcNrc_initAddr = 28'h500; NcNrc_initAddrEn = 1'b1; fc_en = 1'b1;
        @(negedge clk);
        fc_en = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_rst_outst", outst, 3);
        wi = got_q.size();
        rst_n = 1'b0; mem_rd_gnt = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mid_rst");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle_outputs("post_rst");
        chk("stray_words", got_q.size() - wi, 0);
        mem_rd_gnt = 1'b1;

        run_layer(28'h700, 28'h800, 28'h900, 0, 1'b0);

        chk("max_outst_ok", (max_outst <= MO), 1);
        chk("rq_end_overlap", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
